masked_sbox_array: RTL and testbench

MASKED_SBOX_ARRAY -- requirements
Module: masked_sbox_array

---
 rtl/masked_sbox_array.sv | 255 +++++++++++++++++++++++++
 tb/tb_masked_sbox_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_sbox_array.sv
// masked_sbox_array
// N_SBOX parallel first-order masked AES S-box lanes using multiplicative
// masking. Fixed latency of 5 cycles and one operation accepted per cycle,
// with no back-pressure.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      synchronous active-low reset; clears all state
//   in_valid   qualifies inp / mode / PRNG this cycle
//   mode       0 = forward S-box, 1 = inverse S-box (ignored when INV_EN = 0)
//   inp        lane i = {share1, share0} at [16i+15:16i]
//   PRNG       lane i = {kron[2:0], r1[7:0], r0[7:0]} at [19i+18:19i]
//   SB_out     lane i = {share1, share0} of the result
//   out_valid  in_valid delayed by 5 cycles
//   out_mode   mode delayed by 5 cycles (0 when INV_EN = 0)
//   busy       any valid operation in flight
//   inflight   number of valid operations in stages 1..5
//
// Lane flow
//   s0: optional inverse affine, then the first DOM AND level of the masked
//       zero test
//   s1..s3: remaining AND levels of the zero test
//   s4: the delta bit is added, then each share is multiplied by r0
//   s5: the shares are recombined under r0, inverted, converted back with
//       r1, delta is removed and the optional forward affine is applied
module masked_sbox_array #(
    parameter int N_SBOX = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   mode,
    input  logic [16*N_SBOX-1:0]   inp,
    input  logic [19*N_SBOX-1:0]   PRNG,
    output logic [16*N_SBOX-1:0]   SB_out,
    output logic                   out_valid,
    output logic                   out_mode,
    output logic                   busy,
    output logic [2:0]             inflight
);
    localparam int LAT = 5;

    // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254; maps 0 to 0, which the delta correction keeps out of the path
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Linear parts of the AES affine map and its inverse (constants applied separately)
    function automatic logic [7:0] fwd_lin(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]};
    endfunction

    function automatic logic [7:0] inv_lin(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]};
    endfunction

    // Domain-oriented AND: returns {x1y1, x1y0^r, x0y1^r, x0y0}; the cross
    // terms must be registered before compression
    function automatic logic [3:0] dom_and(input logic x0, input logic x1,
                                           input logic y0, input logic y1,
                                           input logic r);
        return {x1 & y1, (x1 & y0) ^ r, (x0 & y1) ^ r, x0 & y0};
    endfunction

    // ------------------------------------------------------------------
    // Control: valid shift register, mode pipeline, occupancy counter
    // ------------------------------------------------------------------
    logic [LAT-1:0] valid_sr_reg;
    logic [LAT-1:0] mode_sr;
    logic [2:0]     inflight_reg;
    logic [2:0]     inflight_next;
    logic           mode_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_sr_reg <= '0;
            inflight_reg <= '0;
        end else begin
            valid_sr_reg <= {valid_sr_reg[LAT-2:0], in_valid};
            inflight_reg <= inflight_next;
        end
    end

    always_comb begin
        inflight_next = inflight_reg;
        if (in_valid && !valid_sr_reg[LAT-1]) begin
            if (inflight_reg != 3'(LAT)) inflight_next = inflight_reg + 3'd1;
        end else if (!in_valid && valid_sr_reg[LAT-1]) begin
            if (inflight_reg != 3'd0) inflight_next = inflight_reg - 3'd1;
        end
    end

    generate
        if (INV_EN) begin : g_mode
            logic [LAT-1:0] mode_sr_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) mode_sr_reg <= '0;
                else        mode_sr_reg <= {mode_sr_reg[LAT-2:0], mode};
            end
            assign mode_sr  = mode_sr_reg;
            assign mode_eff = mode;
        end else begin : g_no_mode
            logic unused_mode;
            assign unused_mode = mode;
            assign mode_sr     = '0;
            assign mode_eff    = 1'b0;
        end
    endgenerate

    assign out_valid = valid_sr_reg[LAT-1];
    assign out_mode  = mode_sr[LAT-1];
    assign inflight  = inflight_reg;
    assign busy      = (inflight_reg != 3'd0);

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_SBOX; gi++) begin : g_lane
            logic [7:0]  sh0, sh1, a0_c, a1_c, r0_c;
            logic [18:0] rnd;
            logic [15:0] l1_c;
            logic [7:0]  l2_c;
            logic [3:0]  l3_c;
            logic [3:0]  z0_c, z1_c;
            logic [1:0]  w0_c, w1_c;
            logic        d0_c, d1_c;
            logic [7:0]  t0_c, t1_c, p_c, q_c, b0_c, b1_c, o0_c, o1_c;

            logic [7:0]  a0_s1_reg, a1_s1_reg, r0_s1_reg, r1_s1_reg;
            logic [1:0]  rk_s1_reg;
            logic [15:0] l1_s1_reg;
            logic [7:0]  a0_s2_reg, a1_s2_reg, r0_s2_reg, r1_s2_reg;
            logic        rk_s2_reg;
            logic [7:0]  l2_s2_reg;
            logic [7:0]  a0_s3_reg, a1_s3_reg, r0_s3_reg, r1_s3_reg;
            logic [3:0]  l3_s3_reg;
            logic [7:0]  t0_s4_reg, t1_s4_reg, rm_s4_reg, r1_s4_reg;
            logic        d0_s4_reg, d1_s4_reg;
            logic [15:0] out_s5_reg;

            assign sh0 = inp[16*gi +: 8];
            assign sh1 = inp[16*gi+8 +: 8];
            // Randomness is only taken from the bus on accepted cycles
            assign rnd  = in_valid ? PRNG[19*gi +: 19] : 19'd0;
            assign r0_c = (rnd[7:0] == 8'h00) ? 8'h01 : rnd[7:0];

            // Inverse mode undoes the affine map first so both modes share the inverter
            assign a0_c = mode_eff ? inv_lin(sh0) : sh0;
            assign a1_c = mode_eff ? (inv_lin(sh1) ^ 8'h05) : sh1;

            // Zero test: delta = AND of all bits of ~a; negating share0 alone negates a.
            // One Kronecker bit refreshes each level of the AND tree.
            always_comb begin
                l1_c = '0;
                for (int j = 0; j < 4; j++)
                    l1_c[4*j +: 4] = dom_and(~a0_c[2*j], a1_c[2*j],
                                             ~a0_c[2*j+1], a1_c[2*j+1], rnd[16]);
            end

            always_comb begin
                z0_c = '0;
                z1_c = '0;
                l2_c = '0;
                for (int j = 0; j < 4; j++) begin
                    z0_c[j] = l1_s1_reg[4*j] ^ l1_s1_reg[4*j+1];
                    z1_c[j] = l1_s1_reg[4*j+3] ^ l1_s1_reg[4*j+2];
                end
                for (int k = 0; k < 2; k++)
                    l2_c[4*k +: 4] = dom_and(z0_c[2*k], z1_c[2*k],
                                             z0_c[2*k+1], z1_c[2*k+1], rk_s1_reg[0]);
            end

            always_comb begin
                w0_c = '0;
                w1_c = '0;
                for (int k = 0; k < 2; k++) begin
                    w0_c[k] = l2_s2_reg[4*k] ^ l2_s2_reg[4*k+1];
                    w1_c[k] = l2_s2_reg[4*k+3] ^ l2_s2_reg[4*k+2];
                end
                l3_c = dom_and(w0_c[0], w1_c[0], w0_c[1], w1_c[1], rk_s2_reg);
            end

            // Adding delta turns a zero input into 1; each share is then
            // multiplied by r0 on its own and kept registered until recombined
            assign d0_c = l3_s3_reg[0] ^ l3_s3_reg[1];
            assign d1_c = l3_s3_reg[3] ^ l3_s3_reg[2];
            assign t0_c = gf_mul(a0_s3_reg ^ {7'd0, d0_c}, r0_s3_reg);
            assign t1_c = gf_mul(a1_s3_reg ^ {7'd0, d1_c}, r0_s3_reg);

            // p = a*r0, so inverting p exposes nothing; q*(r0^r1) ^ q*r1 = q*r0 = a^-1
            assign p_c  = t0_s4_reg ^ t1_s4_reg;
            assign q_c  = gf_inv(p_c);
            assign b0_c = gf_mul(q_c, rm_s4_reg) ^ {7'd0, d0_s4_reg};
            assign b1_c = gf_mul(q_c, r1_s4_reg) ^ {7'd0, d1_s4_reg};
            assign o0_c = mode_sr[LAT-2] ? b0_c : fwd_lin(b0_c);
            assign o1_c = mode_sr[LAT-2] ? b1_c : (fwd_lin(b1_c) ^ 8'h63);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a0_s1_reg <= '0; a1_s1_reg <= '0; r0_s1_reg <= '0; r1_s1_reg <= '0;
                    rk_s1_reg <= '0; l1_s1_reg <= '0;
                    a0_s2_reg <= '0; a1_s2_reg <= '0; r0_s2_reg <= '0; r1_s2_reg <= '0;
                    rk_s2_reg <= '0; l2_s2_reg <= '0;
                    a0_s3_reg <= '0; a1_s3_reg <= '0; r0_s3_reg <= '0; r1_s3_reg <= '0;
                    l3_s3_reg <= '0;
                    t0_s4_reg <= '0; t1_s4_reg <= '0; rm_s4_reg <= '0; r1_s4_reg <= '0;
                    d0_s4_reg <= '0; d1_s4_reg <= '0;
                    out_s5_reg <= '0;
                end else begin
                    a0_s1_reg <= a0_c;      a1_s1_reg <= a1_c;
                    r0_s1_reg <= r0_c;      r1_s1_reg <= rnd[15:8];
                    rk_s1_reg <= rnd[18:17]; l1_s1_reg <= l1_c;
                    a0_s2_reg <= a0_s1_reg; a1_s2_reg <= a1_s1_reg;
                    r0_s2_reg <= r0_s1_reg; r1_s2_reg <= r1_s1_reg;
                    rk_s2_reg <= rk_s1_reg[1]; l2_s2_reg <= l2_c;
                    a0_s3_reg <= a0_s2_reg; a1_s3_reg <= a1_s2_reg;
                    r0_s3_reg <= r0_s2_reg; r1_s3_reg <= r1_s2_reg;
                    l3_s3_reg <= l3_c;
                    t0_s4_reg <= t0_c;      t1_s4_reg <= t1_c;
                    rm_s4_reg <= r0_s3_reg ^ r1_s3_reg;
                    r1_s4_reg <= r1_s3_reg;
                    d0_s4_reg <= d0_c;      d1_s4_reg <= d1_c;
                    out_s5_reg <= {o1_c, o0_c};
                end
            end

            assign SB_out[16*gi +: 16] = out_s5_reg;
        end
    endgenerate

endmodule

// File: tb/tb_masked_sbox_array.sv
module tb_masked_sbox_array;
    localparam int N   = 4;
    localparam int LAT = 5;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic              mode     = 1'b0;
    logic [16*N-1:0]   inp      = '0;
    logic [19*N-1:0]   prng     = '0;
    logic [16*N-1:0]   sb_out;
    logic              out_valid, out_mode, busy;
    logic [2:0]        inflight;

    logic              b_in_valid = 1'b0;
    logic              b_mode     = 1'b0;
    logic [15:0]       b_inp      = '0;
    logic [18:0]       b_prng     = '0;
    logic [15:0]       b_sb_out;
    logic              b_out_valid, b_out_mode, b_busy;
    logic [2:0]        b_inflight;

    masked_sbox_array #(.N_SBOX(N), .INV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .inp(inp),
        .PRNG(prng), .SB_out(sb_out), .out_valid(out_valid), .out_mode(out_mode),
        .busy(busy), .inflight(inflight)
    );

    masked_sbox_array #(.N_SBOX(1), .INV_EN(1'b0)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .mode(b_mode), .inp(b_inp),
        .PRNG(b_prng), .SB_out(b_sb_out), .out_valid(b_out_valid), .out_mode(b_out_mode),
        .busy(b_busy), .inflight(b_inflight)
    );

    typedef struct {
        int              cyc;
        logic            m;
        logic [8*N-1:0]  exp;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t[256];
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: field arithmetic by definition, inverse by search,
    // affine map from its bit equation, inverse S-box by table inversion.
    function automatic int ref_mul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ a;
            a = a << 1;
            if (a & 256) a = a ^ 283;
        end
        return p;
    endfunction

    function automatic int ref_sbox(input int x);
        int inv = 0;
        int res = 0;
        for (int z = 1; z < 256; z++)
            if (x != 0 && ref_mul(x, z) == 1) inv = z;
        for (int i = 0; i < 8; i++) begin
            int bit_v;
            bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
                     (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (99 >> i)) & 1;
            res = res | (bit_v << i);
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle of stimulus at a negedge; expected results are queued
    // for accepted operations only.
    task automatic drive(input logic v, input logic m, input logic [8*N-1:0] vals,
                         input bit a5_r0zero);
        logic [31:0] rnd;
        logic [7:0]  s0;
        exp_t        e;
        in_valid = v;
        mode     = m;
        for (int i = 0; i < N; i++) begin
            rnd = $urandom;
            s0  = rnd[7:0];
            if (a5_r0zero && i == 0) s0 = 8'hA5;
            inp[16*i +: 16] = {s0 ^ vals[8*i +: 8], s0};
            rnd = $urandom;
            prng[19*i +: 19] = rnd[18:0];
            if (a5_r0zero && i == 0) prng[19*i +: 8] = 8'h00;
        end
        if (v && rst_n) begin
            e.cyc = cyc;
            e.m   = m;
            for (int i = 0; i < N; i++)
                e.exp[8*i +: 8] = m ? isbox_t[vals[8*i +: 8]] : sbox_t[vals[8*i +: 8]];
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic [31:0] rnd;
        for (int k = 0; k < n; k++) begin
            rnd = $urandom;
            drive(1'b0, rnd[0], {$urandom, $urandom}, 1'b0);
        end
    endtask

    // Monitor: pops one expectation per out_valid and flags late/missing results
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1, want 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("latency", cyc - mon_e.cyc, LAT);
                check("out_mode", out_mode, mon_e.m);
                for (int i = 0; i < N; i++)
                    check($sformatf("lane%0d_unmask", i),
                          sb_out[16*i +: 8] ^ sb_out[16*i+8 +: 8], mon_e.exp[8*i +: 8]);
            end
        end
        while (sb_q.size() > 0 && (cyc - sb_q[0].cyc) > LAT) begin
            checks++;
            errors++;
            $display("FAIL missing_out_valid: op from cycle %0d not seen, want out_valid at cycle %0d",
                     sb_q[0].cyc, sb_q[0].cyc + LAT);
            void'(sb_q.pop_front());
        end
    end

    initial begin
        logic [31:0]    rnd;
        logic [8*N-1:0] vals;
        logic [7:0]     x, s0;
        int             pat_v[5]  = '{1, 0, 1, 1, 0};
        int             pat_if[5] = '{1, 1, 2, 3, 3};

        for (int v = 0; v < 256; v++) sbox_t[v] = 8'(ref_sbox(v));
        for (int v = 0; v < 256; v++) isbox_t[sbox_t[v]] = 8'(v);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sb_out", sb_out[31:0] | sb_out[63:32], 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_inflight", inflight, 0);
        check("rst_fwd_out", {b_out_valid, b_out_mode, b_busy, b_sb_out}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unmasked zero as {A5,A5} with a zero r0 byte
        vals = {$urandom, $urandom};
        vals[7:0] = 8'h00;
        drive(1'b1, 1'b0, vals, 1'b1);
        idle(7);

        // Fixed value under many fresh masks
        for (int k = 0; k < 1000; k++) drive(1'b1, 1'b0, {N{8'h53}}, 1'b0);
        for (int k = 0; k < 200; k++)  drive(1'b1, 1'b1, {N{8'hED}}, 1'b0);
        idle(7);

        // Full input sweep, streaming, alternating mode
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < N; i++) vals[8*i +: 8] = 8'(k + 67 * i);
            drive(1'b1, k[0], vals, 1'b0);
            check("stream_inflight", inflight, (k < LAT - 1) ? k + 1 : LAT);
            check("stream_busy", busy, 1);
        end
        idle(7);
        check("drained_busy", busy, 0);

        // Valid gap pattern
        for (int k = 0; k < 5; k++) begin
            rnd = $urandom;
            drive(pat_v[k][0], rnd[0], {$urandom, $urandom}, 1'b0);
            check("pattern_inflight", inflight, pat_if[k]);
        end
        idle(7);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            rnd = $urandom;
            drive(rnd[1:0] != 2'b00, rnd[2], {$urandom, $urandom}, 1'b0);
        end
        idle(7);

        // Reset in the 4th cycle of a burst, with in_valid still high
        for (int k = 0; k < 3; k++) drive(1'b1, k[0], {$urandom, $urandom}, 1'b0);
        sb_q.delete();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
        check("midrst_sb_out", sb_out[31:0] | sb_out[63:32], 0);
        check("midrst_busy", busy, 0);
        check("midrst_inflight", inflight, 0);
        check("midrst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        idle(10);

        // Forward-only instance ignores mode
        in_valid = 1'b0;
        for (int t = 0; t < 8; t++) begin
            rnd = $urandom;
            x   = rnd[7:0];
            s0  = rnd[15:8];
            b_inp      = {s0 ^ x, s0};
            rnd        = $urandom;
            b_prng     = rnd[18:0];
            b_mode     = 1'b1;
            b_in_valid = 1'b1;
            @(negedge clk);
            b_in_valid = 1'b0;
            repeat (LAT - 1) @(negedge clk);
            check("fwd_out_valid", b_out_valid, 1);
            check("fwd_out_mode", b_out_mode, 0);
            check("fwd_unmask", b_sb_out[7:0] ^ b_sb_out[15:8], sbox_t[x]);
            @(negedge clk);
        end

        check("queue_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
